prog_loader: RTL and testbench

Boot loader that sits directly upstream of the tp1 CPU.
- Receives a program image as a byte stream from the UART receiver.
- Writes the image into the instruction RAM that the CPU later fetches from.
- Holds the CPU in reset while loading and releases it only after a checksum-verified load.
- Frame on the stream: MAGIC, LEN, LEN data bytes, CSUM.

---
 rtl/cpu_pkg.sv | 22 ++
 rtl/timeout_counter.sv | 39 +++
 rtl/prog_loader.sv | 153 +++++++++++++++
 tb/tb_prog_loader.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types and constants for the tp1 CPU slice.
// The loader FSM state encoding and its default start-of-frame byte live here.
package cpu_pkg;

  localparam logic [7:0] LOADER_MAGIC      = 8'hA5;
  localparam int         LOADER_ADDR_WIDTH = 8;

  typedef enum logic [2:0] {
    LoaderState_IDLE,
    LoaderState_LEN,
    LoaderState_DATA,
    LoaderState_CSUM,
    LoaderState_RUN,
    LoaderState_ERROR
  } LoaderState;

  // A frame is in progress (and the inter-byte timeout armed) only in these states.
  function automatic logic isLoadingState(input LoaderState s);
    return (s == LoaderState_LEN) || (s == LoaderState_DATA) || (s == LoaderState_CSUM);
  endfunction

endpackage

// File: rtl/timeout_counter.sv
// Idle-cycle watchdog: counts enabled cycles without a clear and pulses
// expired for one cycle when the count reaches TIMEOUT_CYCLES-1.
module timeout_counter #(
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic _iClk,
  input  logic _iReset,
  input  logic enable,
  input  logic clear,
  output logic expired
);

  localparam int TIMER_WIDTH = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TIMER_WIDTH-1:0] TIMER_LAST = TIMER_WIDTH'(TIMEOUT_CYCLES - 1);

  logic [TIMER_WIDTH-1:0] timerReg;
  logic [TIMER_WIDTH-1:0] timerNext;

  // An arriving byte (clear) beats expiry in the same cycle.
  assign expired = enable && !clear && (timerReg == TIMER_LAST);

  always_comb begin
    timerNext = timerReg;
    if (!enable || clear || expired) begin
      timerNext = '0;
    end else begin
      timerNext = timerReg + TIMER_WIDTH'(1);
    end
  end

  always_ff @(posedge _iClk or negedge _iReset) begin
    if (!_iReset) begin
      timerReg <= '0;
    end else begin
      timerReg <= timerNext;
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Boot loader for tp1: receives MAGIC, LEN, data, CSUM from the UART, writes the
// image into instruction RAM and releases the CPU only after a good checksum.
module prog_loader
  import cpu_pkg::*;
#(
  parameter logic [7:0] MAGIC          = LOADER_MAGIC,
  parameter int         TIMEOUT_CYCLES = 1_000_000,
  parameter int         ADDR_WIDTH     = LOADER_ADDR_WIDTH
) (
  input  logic                  _iClk,
  input  logic                  _iReset,
  input  logic [7:0]            _iRxData,
  input  logic                  _iRxValid,
  output logic [ADDR_WIDTH-1:0] _oInstMemAddr,
  output logic [7:0]            _oInstMemWData,
  output logic                  _oInstMemWrite,
  output logic                  _oCpuReset,
  output logic                  _oLoading,
  output logic                  _oError
);

  LoaderState stateReg, stateNext;
  logic [8:0]            remainingReg, remainingNext;
  logic [ADDR_WIDTH-1:0] indexReg, indexNext;
  logic [7:0]            sumReg, sumNext;
  logic [ADDR_WIDTH-1:0] addrReg, addrNext;
  logic [7:0]            wDataReg, wDataNext;
  logic                  writeReg, writeNext;
  logic                  cpuResetReg, cpuResetNext;
  logic                  loadingReg, loadingNext;
  logic                  errorReg, errorNext;

  logic timeoutExpired;
  logic magicSeen;

  assign magicSeen = _iRxValid && (_iRxData == MAGIC);

  timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) uTimeout (
    ._iClk   (_iClk),
    ._iReset (_iReset),
    .enable  (isLoadingState(stateReg)),
    .clear   (_iRxValid),
    .expired (timeoutExpired)
  );

  always_comb begin
    stateNext     = stateReg;
    remainingNext = remainingReg;
    indexNext     = indexReg;
    sumNext       = sumReg;
    addrNext      = addrReg;
    wDataNext     = wDataReg;
    writeNext     = 1'b0;
    errorNext     = errorReg;

    unique case (stateReg)
      LoaderState_IDLE, LoaderState_RUN, LoaderState_ERROR: begin
        if (magicSeen) begin
          stateNext = LoaderState_LEN;
        end
      end

      LoaderState_LEN: begin
        if (_iRxValid) begin
          // A length byte of zero encodes a full 256-byte image.
          remainingNext = (_iRxData == 8'd0) ? 9'd256 : {1'b0, _iRxData};
          indexNext     = '0;
          sumNext       = '0;
          stateNext     = LoaderState_DATA;
        end else if (timeoutExpired) begin
          stateNext = LoaderState_ERROR;
          errorNext = 1'b1;
        end
      end

      LoaderState_DATA: begin
        if (_iRxValid) begin
          writeNext     = 1'b1;
          addrNext      = indexReg;
          wDataNext     = _iRxData;
          indexNext     = indexReg + ADDR_WIDTH'(1);
          sumNext       = sumReg + _iRxData;
          remainingNext = remainingReg - 9'd1;
          if (remainingReg == 9'd1) begin
            stateNext = LoaderState_CSUM;
          end
        end else if (timeoutExpired) begin
          stateNext = LoaderState_ERROR;
          errorNext = 1'b1;
        end
      end

      LoaderState_CSUM: begin
        if (_iRxValid) begin
          if (_iRxData == sumReg) begin
            stateNext = LoaderState_RUN;
            errorNext = 1'b0;
          end else begin
            stateNext = LoaderState_ERROR;
            errorNext = 1'b1;
          end
        end else if (timeoutExpired) begin
          stateNext = LoaderState_ERROR;
          errorNext = 1'b1;
        end
      end

      default: begin
        stateNext = LoaderState_IDLE;
      end
    endcase

    // Outputs follow the next state so they are registered yet change on the deciding edge.
    cpuResetNext = (stateNext != LoaderState_RUN);
    loadingNext  = isLoadingState(stateNext);
  end

  always_ff @(posedge _iClk or negedge _iReset) begin
    if (!_iReset) begin
      stateReg     <= LoaderState_IDLE;
      remainingReg <= '0;
      indexReg     <= '0;
      sumReg       <= '0;
      addrReg      <= '0;
      wDataReg     <= '0;
      writeReg     <= 1'b0;
      cpuResetReg  <= 1'b1;
      loadingReg   <= 1'b0;
      errorReg     <= 1'b0;
    end else begin
      stateReg     <= stateNext;
      remainingReg <= remainingNext;
      indexReg     <= indexNext;
      sumReg       <= sumNext;
      addrReg      <= addrNext;
      wDataReg     <= wDataNext;
      writeReg     <= writeNext;
      cpuResetReg  <= cpuResetNext;
      loadingReg   <= loadingNext;
      errorReg     <= errorNext;
    end
  end

  assign _oInstMemAddr  = addrReg;
  assign _oInstMemWData = wDataReg;
  assign _oInstMemWrite = writeReg;
  assign _oCpuReset     = cpuResetReg;
  assign _oLoading      = loadingReg;
  assign _oError        = errorReg;

endmodule

// File: tb/tb_prog_loader.sv
// Directed plus randomized frames for prog_loader, checked against a frame-level
// model of the expected RAM writes, checksum outcome and timeout behaviour.
module tb_prog_loader;

  localparam int         TO      = 16;
  localparam logic [7:0] MAGIC_B = 8'hA5;

  logic       clk;
  logic       rstN;
  logic [7:0] rxData;
  logic       rxValid;
  logic [7:0] memAddr;
  logic [7:0] memWData;
  logic       memWrite;
  logic       cpuReset;
  logic       loading;
  logic       error;

  int checks   = 0;
  int failures = 0;

  logic [15:0] obsQ[$];
  int          writeCount = 0;

  prog_loader #(
    .MAGIC          (MAGIC_B),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    ._iClk          (clk),
    ._iReset        (rstN),
    ._iRxData       (rxData),
    ._iRxValid      (rxValid),
    ._oInstMemAddr  (memAddr),
    ._oInstMemWData (memWData),
    ._oInstMemWrite (memWrite),
    ._oCpuReset     (cpuReset),
    ._oLoading      (loading),
    ._oError        (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (memWrite === 1'b1) begin
      obsQ.push_back({memAddr, memWData});
      writeCount++;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    rxValid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; returns at the next negedge, after the byte was sampled.
  task automatic sendByte(input logic [7:0] b);
    rxData  = b;
    rxValid = 1'b1;
    @(negedge clk);
    rxValid = 1'b0;
    rxData  = 8'($urandom);
  endtask

  task automatic checkResetValues(input string tag);
    check({tag, "_cpu_reset"}, 32'(cpuReset), 32'd1);
    check({tag, "_write"},     32'(memWrite), 32'd0);
    check({tag, "_addr"},      32'(memAddr),  32'd0);
    check({tag, "_wdata"},     32'(memWData), 32'd0);
    check({tag, "_loading"},   32'(loading),  32'd0);
    check({tag, "_error"},     32'(error),    32'd0);
  endtask

  task automatic sendNoise(input int n);
    logic [7:0] b;
    for (int k = 0; k < n; k++) begin
      b = 8'($urandom);
      if (b == MAGIC_B) b = 8'h5A;
      sendByte(b);
      idle($urandom_range(0, 2));
    end
  endtask

  // Model: writes land at addresses 0..n-1 with the body bytes; the CPU is
  // released iff the checksum byte equals the byte sum mod 256.
  task automatic runFrame(input string tag, input logic [7:0] lenByte,
                          input logic [7:0] body[$], input logic [7:0] csumByte,
                          input int maxGap);
    int         n;
    logic [7:0] modelSum;
    logic       ok;
    n = (lenByte == 8'd0) ? 256 : int'(lenByte);
    modelSum = 8'd0;
    foreach (body[i]) modelSum = modelSum + body[i];
    ok = (csumByte == modelSum);
    $display("frame %s len=%0d csum=%02h expect_run=%0d", tag, n, csumByte, ok);
    obsQ.delete();

    sendByte(MAGIC_B);
    check({tag, "_magic_loading"}, 32'(loading), 32'd1);
    check({tag, "_magic_cpu_reset"}, 32'(cpuReset), 32'd1);
    idle($urandom_range(0, maxGap));
    sendByte(lenByte);
    for (int i = 0; i < n; i++) begin
      idle($urandom_range(0, maxGap));
      sendByte(body[i]);
      check({tag, "_write"}, 32'({memWrite, memAddr, memWData}),
            32'({1'b1, 8'(i), body[i]}));
    end
    idle($urandom_range(0, maxGap));
    check({tag, "_cpu_held"}, 32'(cpuReset), 32'd1);
    sendByte(csumByte);
    check({tag, "_cpu_reset"}, 32'(cpuReset), 32'(!ok));
    check({tag, "_error"},     32'(error),    32'(!ok));
    check({tag, "_loading"},   32'(loading),  32'd0);
    idle(2);
    check({tag, "_write_count"}, 32'(obsQ.size()), 32'(n));
  endtask

  initial begin
    logic [7:0] q[$];
    logic [7:0] s;
    logic [7:0] cs;
    int         len;

    rstN    = 1'b0;
    rxValid = 1'b0;
    rxData  = 8'h00;
    repeat (3) @(negedge clk);
    checkResetValues("reset");

    // 1: quiet line after reset release.
    rstN = 1'b1;
    idle(2000);
    check("quiet_writes",    32'(writeCount), 32'd0);
    check("quiet_cpu_reset", 32'(cpuReset),   32'd1);
    check("quiet_error",     32'(error),      32'd0);
    check("quiet_loading",   32'(loading),    32'd0);

    // 3: bad checksum (correct would be 03).
    q.delete(); q.push_back(8'h01); q.push_back(8'h02);
    runFrame("bad_sum", 8'h02, q, 8'hFF, 0);

    // 2: good frame back-to-back, recovering from ERROR.
    q.delete(); q.push_back(8'h10); q.push_back(8'h22); q.push_back(8'h05);
    runFrame("good3", 8'h03, q, 8'h37, 0);

    // 5: non-magic ignored in RUN, then MAGIC re-arms (checked inside runFrame).
    sendByte(8'h55);
    check("run_noise_cpu_reset", 32'(cpuReset), 32'd0);
    check("run_noise_loading",   32'(loading),  32'd0);
    q.delete(); q.push_back(8'h42);
    runFrame("rerun", 8'h01, q, 8'h42, 1);

    // 4: silence after one data byte times out after exactly TO idle cycles.
    obsQ.delete();
    sendByte(MAGIC_B);
    sendByte(8'h04);
    sendByte(8'hAA);
    check("to_write", 32'({memWrite, memAddr, memWData}), 32'({1'b1, 8'h00, 8'hAA}));
    idle(TO - 1);
    check("to_pre_error",   32'(error),   32'd0);
    check("to_pre_loading", 32'(loading), 32'd1);
    idle(1);
    check("to_error",     32'(error),    32'd1);
    check("to_loading",   32'(loading),  32'd0);
    check("to_cpu_reset", 32'(cpuReset), 32'd1);
    idle(2);
    check("to_write_count", 32'(obsQ.size()), 32'd1);
    q.delete(); q.push_back(8'h7E);
    runFrame("recover", 8'h01, q, 8'h7E, 0);

    // 6: LEN=0 means 256 bytes; addresses 0..255 with wrap-free final address 255.
    q.delete();
    for (int i = 0; i < 256; i++) q.push_back(8'h01);
    runFrame("full256", 8'h00, q, 8'h00, 0);

    // Randomized frames with line noise, gaps and occasional corrupt checksums.
    for (int f = 0; f < 10; f++) begin
      obsQ.delete();
      sendNoise($urandom_range(0, 3));
      idle(1);
      check("noise_writes",  32'(obsQ.size()), 32'd0);
      check("noise_loading", 32'(loading),     32'd0);
      len = $urandom_range(1, 40);
      q.delete();
      s = 8'd0;
      for (int i = 0; i < len; i++) begin
        q.push_back(8'($urandom));
        s = s + q[i];
      end
      cs = ($urandom_range(0, 3) == 0) ? (s ^ 8'($urandom_range(1, 255))) : s;
      runFrame("random", 8'(len), q, cs, 3);
    end

    // Leave ERROR set, then reset asynchronously in the middle of DATA.
    q.delete(); q.push_back(8'h01); q.push_back(8'h02);
    runFrame("bad2", 8'h02, q, 8'h00, 0);
    sendByte(MAGIC_B);
    sendByte(8'h10);
    sendByte(8'h11);
    sendByte(8'h22);
    sendByte(8'h33);
    #2;
    rstN = 1'b0;
    #1;
    checkResetValues("async_reset");
    @(negedge clk);
    rstN = 1'b1;
    idle(3);
    check("post_reset_cpu_reset", 32'(cpuReset), 32'd1);
    sendByte(8'h44);
    check("post_reset_write",   32'(memWrite), 32'd0);
    check("post_reset_loading", 32'(loading),  32'd0);
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
